// File: rtl/inspection_arbiter.sv
// Round-robin arbiter sharing one inspection station between two part lanes.
// Grants a lane, starts the station, waits for a result or timeout, then acks the lane.
module inspection_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic             insp_done,
    input  logic             insp_ok,
    output logic             insp_start,
    output logic [1:0]       gnt,
    output logic [1:0]       ack,
    output logic [1:0]       verdict,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StStart = 2'b01,
        StWait  = 2'b10,
        StDone  = 2'b11
    } state_e;

    localparam logic [7:0]       TimeoutVal = 8'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_e     state_q;
    logic [7:0] timer_q;
    logic [7:0] timer_inc;
    logic       last_q;   // 1: lane 1 was served last
    logic [1:0] winner;

    assign timer_inc = timer_q + 8'd1;
    assign state     = state_q;

    // On a tie the lane that was not served last wins.
    always_comb begin
        winner = 2'b00;
        unique case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last_q ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            timer_q    <= 8'd0;
            last_q     <= 1'b1;
            gnt        <= 2'b00;
            ack        <= 2'b00;
            insp_start <= 1'b0;
            busy       <= 1'b0;
            verdict    <= 2'b00;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
        end else begin
            ack        <= 2'b00;
            insp_start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req != 2'b00) begin
                        gnt        <= winner;
                        insp_start <= 1'b1;
                        busy       <= 1'b1;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    timer_q <= 8'd0;
                    state_q <= StWait;
                end
                StWait: begin
                    // A result arriving on the final timer cycle beats the timeout.
                    if (insp_done) begin
                        verdict <= insp_ok ? 2'b01 : 2'b10;
                        if (insp_ok) begin
                            if (pass_cnt != CntMax) pass_cnt <= pass_cnt + CntOne;
                        end else begin
                            if (fail_cnt != CntMax) fail_cnt <= fail_cnt + CntOne;
                        end
                        ack     <= gnt;
                        state_q <= StDone;
                    end else if (timer_inc == TimeoutVal) begin
                        verdict <= 2'b11;
                        if (fail_cnt != CntMax) fail_cnt <= fail_cnt + CntOne;
                        ack     <= gnt;
                        state_q <= StDone;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                StDone: begin
                    last_q  <= gnt[1];
                    gnt     <= 2'b00;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_inspection_arbiter.sv
// Scoreboard bench for inspection_arbiter: driver pushes expected transactions,
// monitor pops and compares on every ack pulse.
`timescale 1ns/1ps
module tb_inspection_arbiter;

    localparam int TIMEOUT = 15;
    localparam int CW      = 4;
    localparam int CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = 2'b00;
    logic          insp_done = 1'b0;
    logic          insp_ok = 1'b0;
    logic          insp_start;
    logic [1:0]    gnt, ack, verdict, state;
    logic [CW-1:0] pass_cnt, fail_cnt;
    logic          busy;

    inspection_arbiter #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .insp_done  (insp_done),
        .insp_ok    (insp_ok),
        .insp_start (insp_start),
        .gnt        (gnt),
        .ack        (ack),
        .verdict    (verdict),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .busy       (busy),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lane;
        int verdict;
        int pass_c;
        int fail_c;
        int wait_c;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    int m_pass = 0;
    int m_fail = 0;
    int m_last = 1;
    int m_verdict = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event missing or unexpected at %0t", name, $time);
    endtask

    function automatic int pick_lane(input logic [1:0] r);
        if (r == 2'b11) return (m_last == 1) ? 0 : 1;
        return r[1] ? 1 : 0;
    endfunction

    // Monitor
    initial begin
        int   cyc = 0;
        int   start_cyc = 0;
        bit   ack_prev = 0;
        bit   start_prev = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                ack_prev = 0;
                start_prev = 0;
            end else begin
                if (ack_prev) begin
                    check("post_ack_gnt", int'(gnt), 0);
                    check("post_ack_busy", int'(busy), 0);
                    check("post_ack_state", int'(state), 0);
                end
                if (start_prev) begin
                    check("start_width", int'(insp_start), 0);
                    check("wait_state", int'(state), 2);
                end
                ack_prev = 0;
                start_prev = 0;
                if (insp_start) begin
                    start_prev = 1;
                    start_cyc = cyc;
                    if (exp_q.size() == 0) fail_now("start_unexpected");
                    else begin
                        check("start_gnt", int'(gnt), 1 << exp_q[0].lane);
                        check("start_busy", int'(busy), 1);
                        check("start_state", int'(state), 1);
                    end
                end
                if (ack != 2'b00) begin
                    ack_prev = 1;
                    if (exp_q.size() == 0) fail_now("ack_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        check("ack_lane", int'(ack), 1 << e.lane);
                        check("done_gnt", int'(gnt), 1 << e.lane);
                        check("done_state", int'(state), 3);
                        check("verdict", int'(verdict), e.verdict);
                        check("pass_cnt", int'(pass_cnt), e.pass_c);
                        check("fail_cnt", int'(fail_cnt), e.fail_c);
                        check("latency", cyc - start_cyc, e.wait_c + 1);
                    end
                end
            end
        end
    end

    task automatic wait_start(output bit seen);
        seen = 0;
        for (int g = 0; g < 4 && !seen; g++) begin
            @(negedge clk);
            seen = insp_start;
        end
    endtask

    // done_at: WAIT cycle (1..TIMEOUT) carrying insp_done, 0 for none.
    task automatic run_txn(input logic [1:0] r, input int done_at, input logic ok);
        exp_t e;
        bit   seen;
        e.lane = pick_lane(r);
        if (done_at >= 1 && done_at <= TIMEOUT) begin
            e.verdict = ok ? 1 : 2;
            e.wait_c  = done_at;
        end else begin
            e.verdict = 3;
            e.wait_c  = TIMEOUT;
        end
        if (e.verdict == 1) begin
            if (m_pass < CMAX) m_pass++;
        end else if (m_fail < CMAX) begin
            m_fail++;
        end
        m_last = e.lane;
        m_verdict = e.verdict;
        e.pass_c = m_pass;
        e.fail_c = m_fail;
        exp_q.push_back(e);
        req = r;
        wait_start(seen);
        if (!seen) begin
            fail_now("start_timeout");
            exp_q.delete();
            req = 2'b00;
            return;
        end
        for (int k = 1; k <= done_at && k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == done_at) begin
                insp_done = 1'b1;
                insp_ok   = ok;
            end
        end
        seen = 0;
        for (int g = 0; g < TIMEOUT + 5 && !seen; g++) begin
            @(negedge clk);
            insp_done = 1'b0;
            seen = (ack != 2'b00);
        end
        if (!seen) begin
            fail_now("ack_timeout");
            exp_q.delete();
            req = 2'b00;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 2'b00;
        insp_done = 1'b0;
        exp_q.delete();
        m_pass = 0;
        m_fail = 0;
        m_last = 1;
        m_verdict = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_idle(input string name);
        check({name, "_gnt"}, int'(gnt), 0);
        check({name, "_ack"}, int'(ack), 0);
        check({name, "_start"}, int'(insp_start), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_state"}, int'(state), 0);
        check({name, "_verdict"}, int'(verdict), m_verdict);
        check({name, "_pass"}, int'(pass_cnt), m_pass);
        check({name, "_fail"}, int'(fail_cnt), m_fail);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   seen;
        int   gap;

        do_reset();
        chk_idle("reset");
        repeat (10) begin
            @(negedge clk);
            chk_idle("idle_hold");
        end

        // Single lane pass on the 3rd WAIT cycle
        run_txn(2'b01, 3, 1'b1);

        // Tie round-robin, all fails
        do_reset();
        repeat (4) run_txn(2'b11, 2, 1'b0);
        req = 2'b00;
        @(negedge clk);
        chk_idle("after_tie");

        // Timeout, then result on the last WAIT cycle
        do_reset();
        run_txn(2'b01, 0, 1'b0);
        run_txn(2'b10, TIMEOUT, 1'b1);
        run_txn(2'b01, 1, 1'b1);

        // Saturation and stray insp_done in IDLE
        do_reset();
        repeat (17) run_txn(2'($urandom_range(1, 3)), $urandom_range(1, TIMEOUT), 1'b1);
        req = 2'b00;
        @(negedge clk);
        insp_done = 1'b1;
        insp_ok = 1'b0;
        @(negedge clk);
        insp_done = 1'b0;
        @(negedge clk);
        chk_idle("stray_done");

        // Reset during WAIT aborts without ack
        run_txn(2'b10, 0, 1'b0);
        e.lane = pick_lane(2'b01);
        e.verdict = 0;
        e.pass_c = 0;
        e.fail_c = 0;
        e.wait_c = 0;
        exp_q.push_back(e);
        req = 2'b01;
        wait_start(seen);
        if (!seen) fail_now("abort_start");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_pass = 0;
        m_fail = 0;
        m_last = 1;
        m_verdict = 0;
        req = 2'b00;
        chk_idle("async_reset");
        @(negedge clk);
        chk_idle("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(2'b10, 2, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                req = 2'b00;
                gap = $urandom_range(1, 3);
                repeat (gap) @(negedge clk);
            end
            run_txn(2'($urandom_range(1, 3)),
                    ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TIMEOUT),
                    1'($urandom_range(0, 1)));
        end
        req = 2'b00;
        repeat (2) @(negedge clk);
        chk_idle("final");
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
